// File: rtl/interboard_tx_link.sv
// Transmit side of the board-to-board link: packs a 24-bit message into four
// 6-bit words sent over a 4-phase Request_out/Ack_in handshake.
// Optional build macro INTERBOARD_PARITY_EN sets the packet LSB to even parity.
module interboard_tx_link #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       transmit,
    input  logic       ctrl_en,
    input  logic       ctrl_move_dir,
    input  logic [4:0] ctrl_block_x,
    input  logic [2:0] ctrl_block_y,
    input  logic [3:0] ctrl_msg_type,
    input  logic [5:0] ctrl_card,
    input  logic [2:0] ctrl_sel_len,
    input  logic       Ack_in,
    output logic       send_ready,
    output logic       Request_out,
    output logic [5:0] inter_data_out,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic                   ack_s;
    logic [22:0]            body;
    logic                   parity;
    logic [23:0]            pkt, pkt_next;
    logic [1:0]             index, index_next;
    logic [5:0]             data_next;
    logic                   req_next, done_next, error_next;
    logic [CW-1:0]          counter;
    logic                   timer_hit;

    assign body = {ctrl_msg_type, ctrl_en, ctrl_move_dir, ctrl_block_x,
                   ctrl_block_y, ctrl_card, ctrl_sel_len};

`ifdef INTERBOARD_PARITY_EN
    assign parity = ^body;
`else
    assign parity = 1'b0;
`endif

    function automatic logic [5:0] word_at(input logic [23:0] p, input logic [1:0] i);
        case (i)
            2'd0:    word_at = p[23:18];
            2'd1:    word_at = p[17:12];
            2'd2:    word_at = p[11:6];
            default: word_at = p[5:0];
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ack_sync <= '0;
        else      ack_sync <= {ack_sync[SYNC_STAGES-2:0], Ack_in};
    end
    assign ack_s = ack_sync[SYNC_STAGES-1];

    assign send_ready = (state == IDLE);
    assign timer_hit  = (counter == T_LAST);

    // Data is loaded on the edge entering SETUP so it is stable a full cycle before Request rises.
    always_comb begin
        state_next = state;
        pkt_next   = pkt;
        index_next = index;
        data_next  = inter_data_out;
        req_next   = 1'b0;
        done_next  = 1'b0;
        error_next = 1'b0;
        case (state)
            IDLE: begin
                if (transmit) begin
                    pkt_next   = {body, parity};
                    index_next = 2'd0;
                    data_next  = body[22:17];
                    state_next = SETUP;
                end
            end
            SETUP: begin
                req_next   = 1'b1;
                state_next = REQ_HI;
            end
            REQ_HI: begin
                req_next = 1'b1;
                if (ack_s) begin
                    req_next   = 1'b0;
                    state_next = REQ_LO;
                end else if (timer_hit) begin
                    req_next   = 1'b0;
                    error_next = 1'b1;
                    state_next = IDLE;
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    if (index == 2'd3) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        index_next = index + 2'd1;
                        data_next  = word_at(pkt, index + 2'd1);
                        state_next = SETUP;
                    end
                end else if (timer_hit) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            pkt            <= '0;
            index          <= '0;
            inter_data_out <= '0;
            Request_out    <= 1'b0;
            tx_done        <= 1'b0;
            tx_error       <= 1'b0;
            counter        <= '0;
        end else begin
            state          <= state_next;
            pkt            <= pkt_next;
            index          <= index_next;
            inter_data_out <= data_next;
            Request_out    <= req_next;
            tx_done        <= done_next;
            tx_error       <= error_next;
            if (state_next != state)
                counter <= '0;
            else if (state == REQ_HI || state == REQ_LO)
                counter <= counter + 1'b1;
        end
    end

endmodule

// File: tb/tb_interboard_tx_link.sv
// Self-checking bench for interboard_tx_link: random messages against an
// arithmetic packet model, with a behavioural peer answering the handshake.
module tb_interboard_tx_link;

    typedef struct packed {
        logic [3:0] mt;
        logic       en;
        logic       dir;
        logic [4:0] x;
        logic [2:0] y;
        logic [5:0] card;
        logic [2:0] sel;
    } msg_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       transmit = 1'b0;
    logic       ctrl_en = 1'b0, ctrl_move_dir = 1'b0;
    logic [4:0] ctrl_block_x = '0;
    logic [2:0] ctrl_block_y = '0;
    logic [3:0] ctrl_msg_type = '0;
    logic [5:0] ctrl_card = '0;
    logic [2:0] ctrl_sel_len = '0;
    logic       Ack_in = 1'b0;
    logic       send_ready, Request_out, tx_done, tx_error;
    logic [5:0] inter_data_out;
    logic       ack_to = 1'b0;
    logic       send_ready_to, request_to, done_to, error_to;
    logic [5:0] data_to;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0, err_cnt = 0, done_to_cnt = 0, unstable = 0;
    int peer_hold = 0;
    bit peer_on = 1'b0;
    bit prev_req = 1'b0;
    int ack_cnt = 0;
    logic [5:0] held = '0;
    logic [5:0] captured[$];

    always #5 clk = ~clk;

    interboard_tx_link #(.TIMEOUT_CYCLES(1000), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .transmit(transmit), .ctrl_en(ctrl_en),
        .ctrl_move_dir(ctrl_move_dir), .ctrl_block_x(ctrl_block_x),
        .ctrl_block_y(ctrl_block_y), .ctrl_msg_type(ctrl_msg_type),
        .ctrl_card(ctrl_card), .ctrl_sel_len(ctrl_sel_len), .Ack_in(Ack_in),
        .send_ready(send_ready), .Request_out(Request_out),
        .inter_data_out(inter_data_out), .tx_done(tx_done), .tx_error(tx_error)
    );

    interboard_tx_link #(.TIMEOUT_CYCLES(16), .SYNC_STAGES(2)) dut_to (
        .clk(clk), .rst(rst), .transmit(transmit), .ctrl_en(ctrl_en),
        .ctrl_move_dir(ctrl_move_dir), .ctrl_block_x(ctrl_block_x),
        .ctrl_block_y(ctrl_block_y), .ctrl_msg_type(ctrl_msg_type),
        .ctrl_card(ctrl_card), .ctrl_sel_len(ctrl_sel_len), .Ack_in(ack_to),
        .send_ready(send_ready_to), .Request_out(request_to),
        .inter_data_out(data_to), .tx_done(done_to), .tx_error(error_to)
    );

    // Reference: packet built by weighted sums of the fields, words cut by shifting.
    function automatic logic [5:0] model_word(input msg_t m, input int i);
        int unsigned p;
        p = int'(m.mt) * (1 << 20) + int'(m.en) * (1 << 19) + int'(m.dir) * (1 << 18)
          + int'(m.x) * (1 << 13) + int'(m.y) * (1 << 10) + int'(m.card) * 16
          + int'(m.sel) * 2;
`ifdef INTERBOARD_PARITY_EN
        p = p + ($countones(p) % 2);
`endif
        return 6'((p >> (18 - 6 * i)) % 64);
    endfunction

    function automatic msg_t rand_msg();
        msg_t m;
        m = msg_t'($urandom);
        return m;
    endfunction

    // Behavioural peer plus pulse monitors.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_done)  done_cnt++;
            if (tx_error) err_cnt++;
            if (done_to)  done_to_cnt++;
            if (peer_on) begin
                if (Request_out && !prev_req) begin
                    captured.push_back(inter_data_out);
                    held = inter_data_out;
                end
                if (Request_out && inter_data_out !== held) unstable++;
                if (Ack_in) ack_cnt++;
                if (Request_out && !Ack_in) begin
                    Ack_in  = 1'b1;
                    ack_cnt = 0;
                end else if (!Request_out && Ack_in && ack_cnt >= peer_hold) begin
                    Ack_in = 1'b0;
                end
            end
            prev_req = Request_out;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        Ack_in = 1'b0;
        transmit = 1'b0;
        peer_on = 1'b0;
        peer_hold = 0;
        repeat (3) @(negedge clk);
        captured.delete();
        done_cnt = 0; err_cnt = 0; done_to_cnt = 0; unstable = 0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input msg_t m);
        @(negedge clk);
        {ctrl_msg_type, ctrl_en, ctrl_move_dir, ctrl_block_x, ctrl_block_y,
         ctrl_card, ctrl_sel_len} = m;
        transmit = 1'b1;
        @(negedge clk);
        transmit = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s: no tx_done within %0d cycles, got done_cnt=%0d want >=1", name, budget, done_cnt);
        end
    endtask

    task automatic check_words(input msg_t m, input int first, input string name);
        checks++;
        if (captured.size() != 4 - first) begin
            errors++;
            $display("FAIL %s count: got %0d words want %0d", name, captured.size(), 4 - first);
        end
        for (int i = first; i < 4; i++) begin
            if (i - first < captured.size()) begin
                checks++;
                if (captured[i-first] !== model_word(m, i)) begin
                    errors++;
                    $display("FAIL %s word%0d: got 0x%02h want 0x%02h", name, i, captured[i-first], model_word(m, i));
                end
            end
        end
    endtask

    task automatic test_reset();
        int n = 0;
        do_reset();
        checks++;
        if ({send_ready, Request_out, inter_data_out, tx_done, tx_error} !== {1'b1, 1'b0, 6'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle: got rdy=%b req=%b data=%h done=%b err=%b want 1 0 00 0 0",
                     send_ready, Request_out, inter_data_out, tx_done, tx_error);
        end
        send(rand_msg());
        while (!Request_out && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (!Request_out) begin errors++; $display("FAIL reset_reach_req: got req=0 want 1"); end
        rst = 1'b0;
        #1;
        checks++;
        if ({send_ready, Request_out, inter_data_out} !== {1'b1, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL reset_async: got rdy=%b req=%b data=%h want 1 0 00", send_ready, Request_out, inter_data_out);
        end
        @(posedge clk); #1;
        checks++;
        if ({tx_done, tx_error, Request_out} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pulses: got done=%b err=%b req=%b want 0 0 0", tx_done, tx_error, Request_out);
        end
    endtask

    task automatic test_normal();
        msg_t m;
        do_reset();
        peer_on = 1'b1;
        m = '{mt: 4'd3, en: 1'b1, dir: 1'b0, x: 5'd17, y: 3'd5, card: 6'd42, sel: 3'd2};
        send(m);
        wait_done(300, "normal");
        repeat (5) @(negedge clk);
        check_words(m, 0, "normal");
        checks++;
        if (done_cnt != 1 || err_cnt != 0 || unstable != 0) begin
            errors++;
            $display("FAIL normal_pulses: got done=%0d err=%0d unstable=%0d want 1 0 0", done_cnt, err_cnt, unstable);
        end
        checks++;
        if (inter_data_out !== model_word(m, 3) || !send_ready) begin
            errors++;
            $display("FAIL normal_hold: got data=%h rdy=%b want %h 1", inter_data_out, send_ready, model_word(m, 3));
        end
    endtask

    task automatic test_random();
        msg_t m;
        for (int k = 0; k < 6; k++) begin
            do_reset();
            peer_on = 1'b1;
            m = rand_msg();
            send(m);
            wait_done(300, "random");
            repeat (3) @(negedge clk);
            check_words(m, 0, "random");
            checks++;
            if (done_cnt != 1 || unstable != 0) begin
                errors++;
                $display("FAIL random_pulses: got done=%0d unstable=%0d want 1 0", done_cnt, unstable);
            end
        end
    endtask

    task automatic test_busy_drop();
        msg_t a, b;
        int n = 0;
        do_reset();
        peer_on = 1'b1;
        a = rand_msg();
        b = ~a;
        send(a);
        while (captured.size() < 2 && n < 200) begin @(negedge clk); n++; end
        send(b);
        wait_done(300, "busy");
        repeat (30) @(negedge clk);
        check_words(a, 0, "busy");
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL busy_done: got %0d pulses want 1", done_cnt);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        do_reset();
        peer_on = 1'b1;
        send(rand_msg());
        while (!request_to && n < 20) @(negedge clk);
        n = 0;
        while (!error_to && n < 40) begin @(posedge clk); #1; n++; end
        checks++;
        if (n != 16 || request_to !== 1'b0) begin
            errors++;
            $display("FAIL timeout_delay: got err after %0d cycles req=%b want 16 0", n, request_to);
        end
        @(posedge clk); #1;
        checks++;
        if (send_ready_to !== 1'b1 || error_to !== 1'b0 || done_to_cnt != 0) begin
            errors++;
            $display("FAIL timeout_after: got rdy=%b err=%b done_cnt=%0d want 1 0 0", send_ready_to, error_to, done_to_cnt);
        end
    endtask

    task automatic test_slow_peer();
        msg_t m;
        do_reset();
        peer_on = 1'b1;
        peer_hold = 50;
        m = rand_msg();
        send(m);
        wait_done(2000, "slow");
        repeat (3) @(negedge clk);
        check_words(m, 0, "slow");
        checks++;
        if (err_cnt != 0 || done_cnt != 1) begin
            errors++;
            $display("FAIL slow_pulses: got err=%0d done=%0d want 0 1", err_cnt, done_cnt);
        end
    endtask

    task automatic test_stuck_ack();
        msg_t m;
        int highs = 0;
        do_reset();
        Ack_in = 1'b1;
        repeat (4) @(negedge clk);
        m = rand_msg();
        send(m);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (Request_out) highs++;
        end
        checks++;
        if (highs != 1 || Request_out || send_ready || inter_data_out !== model_word(m, 0)) begin
            errors++;
            $display("FAIL stuck_wait: got highs=%0d req=%b rdy=%b data=%h want 1 0 0 %h",
                     highs, Request_out, send_ready, inter_data_out, model_word(m, 0));
        end
        Ack_in = 1'b0;
        peer_on = 1'b1;
        wait_done(300, "stuck");
        repeat (3) @(negedge clk);
        check_words(m, 1, "stuck");
    endtask

    initial begin
        test_reset();
        test_normal();
        test_random();
        test_busy_drop();
        test_timeout();
        test_slow_peer();
        test_stuck_ack();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
